sa_axi_txn_arbiter: RTL and testbench
=====================================

# sa_axi_txn_arbiter

Shares the single user-side port of the SA AXI4 full master (mode, off-memory addresses, wdata/rdata, init/done handshake) between a load requester and a store requester. It arbitrates the two requesters, sequences the master's init_axi_txn / txn_done level handshake, and returns read data, completion and error status to the granted requester. It sits between the systolic-array buffer controllers and the AXI4 master.

## Interface
- ADDR_WIDTH, 9, off-memory word address width (addra/addrb)
- DATA_WIDTH, 128, data word width
- CNT_WIDTH, 16, completed-transaction counter width
- axi_aclk  in  1  clock; all logic on the rising edge
- axi_aresetn  in  1  reset, asynchronous, active-low
- ld_req  in  1  load request; payload stable while high
- ld_addr  in  ADDR_WIDTH  load word address
- ld_ack  out  1  1-cycle pulse: load request accepted, payload captured
- ld_done  out  1  1-cycle pulse: load complete
- ld_rdata  out  DATA_WIDTH  read word; valid with ld_done, held until next ld_done
- ld_err  out  1  valid with ld_done: master reported error
- st_req  in  1  store request; payload stable while high
- st_addr  in  ADDR_WIDTH  store word address
- st_wdata  in  DATA_WIDTH  store word
- st_ack / st_done / st_err  out  1 each  as ld_* for stores
- c_m00_mode  out  2  to master: 00 M_IDLE, 01 M_LOAD, 10 M_STORE
- c_m00_off_mem_addra  out  ADDR_WIDTH  to master: store address
- c_m00_off_mem_addrb  out  ADDR_WIDTH  to master: load address
- c_m00_wdata  out  DATA_WIDTH  to master: store data
- c_m00_rdata  in  DATA_WIDTH  from master: load data
- m00_axi_init_axi_txn  out  1  level; held high until txn_done seen
- m00_axi_txn_done  in  1  level from master
- m00_axi_error  in  1  from master
- busy  out  1  high in any state other than IDLE
- txn_cnt  out  CNT_WIDTH  completed transactions, wraps to 0

## Operation
- States: IDLE, BUSY, DRAIN.
- IDLE: if (ld_req or st_req) and m00_axi_txn_done==0: select winner, pulse its ack, register mode (LOAD/STORE), address (load->addrb, store->addra; other address register unchanged), wdata (store only), init_axi_txn<=1, clear err accumulator, go BUSY. If txn_done==1, no grant.
- BUSY: err accumulator |= m00_axi_error each cycle. On txn_done==1: init<=0; pulse winner's done; winner's err <= accumulator | m00_axi_error; for load, ld_rdata <= c_m00_rdata; txn_cnt+1; go DRAIN. Mode/addr/wdata held throughout BUSY.
- DRAIN: wait txn_done==0; then mode<=M_IDLE, go IDLE.
- Arbitration (default round-robin): last_grant flag; both requesting -> grant the one not last granted; single requester always wins. last_grant resets to "store", so load wins first tie.
- Request dropped before ack: simply not granted. req still high after done: eligible again in next IDLE.
- Reset (asynchronous, any state incl. mid-BUSY): state IDLE, init 0, mode 00, addra/addrb/wdata 0, all ack/done/err 0, ld_rdata 0, txn_cnt 0, busy 0, last_grant=store. Aborted transaction gets no done; requester re-requests.

## Timing
- Request sampled at edge N in IDLE (txn_done low) -> ack and init_axi_txn high from edge N; ack low from N+1.
- txn_done sampled high at edge M -> done/err/rdata valid and init low from M; done low from M+1.
- Fastest turnaround: DRAIN exits the edge after txn_done low is sampled; IDLE grants at the following edge (min 2 cycles from DRAIN entry with txn_done already low).
- ack and done never coincide; at most one transaction in flight.

## Configuration
- SA_ARB_FIXED_PRIO_EN: defined -> fixed priority, load always wins ties, last_grant unused. Undefined -> round-robin as above.

## Test plan
- Single store: st_req, st_addr=0x005, st_wdata=0x19 -> st_ack 1 cycle, mode=10, addra=0x005, init held until model done; st_done 1 cycle, st_err=0, txn_cnt=1.
- Single load: ld_addr=0x005, model returns 0x19 -> mode=01, addrb=0x005, ld_done with ld_rdata=0x19, held after done.
- Simultaneous ld_req and st_req held for 4 transactions -> grant order L,S,L,S (round-robin); with SA_ARB_FIXED_PRIO_EN -> L,L,L,L.
- Model asserts m00_axi_error one cycle mid-BUSY on a store -> st_err=1 with st_done; next transaction err=0.
- txn_done held high 3 cycles after deassert of init with st_req pending -> no ack until txn_done low, mode=00 in IDLE.
- aresetn low mid-BUSY -> init, mode, busy 0 immediately (asynchronous); no done; txn_cnt=0; re-held ld_req granted after release.

Source files
------------

// File: rtl/sa_axi_txn_arbiter.sv
// Shares the SA AXI4 master user port between a load and a store requester.
// Build option: SA_ARB_FIXED_PRIO_EN selects fixed load-first priority (default round-robin).
module sa_axi_txn_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    output logic                  ld_ack,
    output logic                  ld_done,
    output logic [DATA_WIDTH-1:0] ld_rdata,
    output logic                  ld_err,
    input  logic                  st_req,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_wdata,
    output logic                  st_ack,
    output logic                  st_done,
    output logic                  st_err,
    output logic [1:0]            c_m00_mode,
    output logic [ADDR_WIDTH-1:0] c_m00_off_mem_addra,
    output logic [ADDR_WIDTH-1:0] c_m00_off_mem_addrb,
    output logic [DATA_WIDTH-1:0] c_m00_wdata,
    input  logic [DATA_WIDTH-1:0] c_m00_rdata,
    output logic                  m00_axi_init_axi_txn,
    input  logic                  m00_axi_txn_done,
    input  logic                  m00_axi_error,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  txn_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [1:0] M_IDLE  = 2'b00;
    localparam logic [1:0] M_LOAD  = 2'b01;
    localparam logic [1:0] M_STORE = 2'b10;

    logic [1:0]            r_state;
    logic                  r_init;
    logic                  r_acc;
    logic [1:0]            r_mode;
    logic [ADDR_WIDTH-1:0] r_addra;
    logic [ADDR_WIDTH-1:0] r_addrb;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_ld_ack;
    logic                  r_st_ack;
    logic                  r_ld_done;
    logic                  r_st_done;
    logic                  r_ld_err;
    logic                  r_st_err;
    logic [DATA_WIDTH-1:0] r_ld_rdata;
    logic [CNT_WIDTH-1:0]  r_txn_cnt;

    logic w_grant;
    logic w_pick_st;
    logic w_finish;
    logic w_drained;
    logic w_is_st;
    logic w_err_fin;

    // A master still showing txn_done from a previous transaction blocks new grants.
    assign w_grant   = (r_state == ST_IDLE) & (ld_req | st_req) & ~m00_axi_txn_done;
    assign w_finish  = (r_state == ST_BUSY) & m00_axi_txn_done;
    assign w_drained = (r_state == ST_DRAIN) & ~m00_axi_txn_done;
    assign w_is_st   = (r_mode == M_STORE);
    assign w_err_fin = r_acc | m00_axi_error;

`ifdef SA_ARB_FIXED_PRIO_EN
    assign w_pick_st = ~ld_req;
`else
    logic r_last_st;

    // On a tie the requester that did not win last time is served.
    assign w_pick_st = st_req & ~(ld_req & r_last_st);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_last_st <= 1'b1;
        end else if (w_grant) begin
            r_last_st <= w_pick_st;
        end
    end
`endif

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state <= ST_IDLE;
            r_init  <= 1'b0;
            r_acc   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state <= ST_BUSY;
                        r_init  <= 1'b1;
                        r_acc   <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (m00_axi_txn_done) begin
                        r_state <= ST_DRAIN;
                        r_init  <= 1'b0;
                    end else begin
                        r_acc <= r_acc | m00_axi_error;
                    end
                end
                ST_DRAIN: begin
                    if (!m00_axi_txn_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_init  <= 1'b0;
                end
            endcase
        end
    end

    // Request capture: the address register of the other direction keeps its value.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_ld_ack <= 1'b0;
            r_st_ack <= 1'b0;
            r_mode   <= M_IDLE;
            r_addra  <= '0;
            r_addrb  <= '0;
            r_wdata  <= '0;
        end else begin
            r_ld_ack <= w_grant & ~w_pick_st;
            r_st_ack <= w_grant & w_pick_st;
            if (w_grant) begin
                if (w_pick_st) begin
                    r_mode  <= M_STORE;
                    r_addra <= st_addr;
                    r_wdata <= st_wdata;
                end else begin
                    r_mode  <= M_LOAD;
                    r_addrb <= ld_addr;
                end
            end else if (w_drained) begin
                r_mode <= M_IDLE;
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_ld_done  <= 1'b0;
            r_st_done  <= 1'b0;
            r_ld_err   <= 1'b0;
            r_st_err   <= 1'b0;
            r_ld_rdata <= '0;
            r_txn_cnt  <= '0;
        end else begin
            r_ld_done <= w_finish & ~w_is_st;
            r_st_done <= w_finish & w_is_st;
            if (w_finish) begin
                r_txn_cnt <= r_txn_cnt + CNT_WIDTH'(1);
                if (w_is_st) begin
                    r_st_err <= w_err_fin;
                end else begin
                    r_ld_err   <= w_err_fin;
                    r_ld_rdata <= c_m00_rdata;
                end
            end
        end
    end

    assign ld_ack               = r_ld_ack;
    assign st_ack               = r_st_ack;
    assign ld_done              = r_ld_done;
    assign st_done              = r_st_done;
    assign ld_err               = r_ld_err;
    assign st_err               = r_st_err;
    assign ld_rdata             = r_ld_rdata;
    assign c_m00_mode           = r_mode;
    assign c_m00_off_mem_addra  = r_addra;
    assign c_m00_off_mem_addrb  = r_addrb;
    assign c_m00_wdata          = r_wdata;
    assign m00_axi_init_axi_txn = r_init;
    assign busy                 = (r_state != ST_IDLE);
    assign txn_cnt              = r_txn_cnt;

endmodule

// File: tb/tb_sa_axi_txn_arbiter.sv
// Bench for sa_axi_txn_arbiter: transaction-level reference model, AXI master model, directed and random traffic.
module tb_sa_axi_txn_arbiter;
    localparam int AW = 9;
    localparam int DW = 128;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic          st_req = 1'b0;
    logic [AW-1:0] st_addr = '0;
    logic [DW-1:0] st_wdata = '0;
    logic [DW-1:0] rdata_in = '0;
    logic          done_in = 1'b0;
    logic          err_in = 1'b0;

    logic          ld_ack, ld_done, ld_err, st_ack, st_done, st_err;
    logic [DW-1:0] ld_rdata, wdata_o;
    logic [1:0]    mode_o;
    logic [AW-1:0] addra_o, addrb_o;
    logic          init_o, busy;
    logic [CW-1:0] txn_cnt;

    sa_axi_txn_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_ack(ld_ack), .ld_done(ld_done),
        .ld_rdata(ld_rdata), .ld_err(ld_err),
        .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata),
        .st_ack(st_ack), .st_done(st_done), .st_err(st_err),
        .c_m00_mode(mode_o), .c_m00_off_mem_addra(addra_o), .c_m00_off_mem_addrb(addrb_o),
        .c_m00_wdata(wdata_o), .c_m00_rdata(rdata_in),
        .m00_axi_init_axi_txn(init_o), .m00_axi_txn_done(done_in), .m00_axi_error(err_in),
        .busy(busy), .txn_cnt(txn_cnt)
    );

    int errs = 0;
    int checks = 0;

    // knobs
    bit rnd = 0, err_knob = 0, force_done = 0, ld_hold = 0, st_hold = 0, rst_rel = 0;
    int dly_knob = 1, hold_knob = 0, ld_pend = 0, st_pend = 0;

    // master model
    bit mpend = 0, mdone = 0;
    int mcnt = 0, mhold = 0;
    logic [DW-1:0] mst_mem [0:(1<<AW)-1];

    // reference model
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            m_ph;
    bit            m_st, m_last_st, m_acc;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          e_ld_ack, e_st_ack, e_ld_done, e_st_done, e_ld_err, e_st_err, e_init, e_busy;
    logic [DW-1:0] e_ld_rdata, e_wdata;
    logic [1:0]    e_mode;
    logic [AW-1:0] e_addra, e_addrb;
    logic [CW-1:0] e_cnt;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            if (errs <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_last_st = 1; m_acc = 0; m_st = 0;
        e_ld_ack = 0; e_st_ack = 0; e_ld_done = 0; e_st_done = 0;
        e_ld_err = 0; e_st_err = 0; e_init = 0; e_busy = 0;
        e_ld_rdata = '0; e_wdata = '0; e_mode = 2'b00; e_addra = '0; e_addrb = '0; e_cnt = '0;
    endtask

    // Predicts outputs after the next rising edge from the inputs now applied.
    task automatic model_step();
        e_ld_ack = 0; e_st_ack = 0; e_ld_done = 0; e_st_done = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (m_ph)
            0: if ((ld_req || st_req) && !done_in) begin
`ifdef SA_ARB_FIXED_PRIO_EN
                m_st = !ld_req;
`else
                m_st = st_req && !(ld_req && m_last_st);
`endif
                m_last_st = m_st;
                if (m_st) begin
                    e_st_ack = 1; e_mode = 2'b10; e_addra = st_addr; e_wdata = st_wdata;
                    m_addr = st_addr; m_data = st_wdata;
                end else begin
                    e_ld_ack = 1; e_mode = 2'b01; e_addrb = ld_addr; m_addr = ld_addr;
                end
                e_init = 1; m_acc = 0; m_ph = 1;
            end
            1: if (done_in) begin
                e_init = 0; e_cnt = e_cnt + 1'b1; m_ph = 2;
                if (m_st) begin
                    e_st_done = 1; e_st_err = m_acc | err_in; ref_mem[m_addr] = m_data;
                end else begin
                    e_ld_done = 1; e_ld_err = m_acc | err_in; e_ld_rdata = ref_mem[m_addr];
                end
            end else begin
                m_acc = m_acc | err_in;
            end
            default: if (!done_in) begin
                e_mode = 2'b00; m_ph = 0;
            end
        endcase
        e_busy = (m_ph != 0);
    endtask

    task automatic compare();
        chk("ld_ack", ld_ack, e_ld_ack);
        chk("st_ack", st_ack, e_st_ack);
        chk("ld_done", ld_done, e_ld_done);
        chk("st_done", st_done, e_st_done);
        chk("ld_rdata", ld_rdata, e_ld_rdata);
        if (e_ld_done) chk("ld_err", ld_err, e_ld_err);
        if (e_st_done) chk("st_err", st_err, e_st_err);
        chk("mode", mode_o, e_mode);
        chk("addra", addra_o, e_addra);
        chk("addrb", addrb_o, e_addrb);
        chk("wdata", wdata_o, e_wdata);
        chk("init", init_o, e_init);
        chk("busy", busy, e_busy);
        chk("txn_cnt", txn_cnt, e_cnt);
    endtask

    task automatic req_stim();
        if (ld_ack) begin
            if (ld_pend > 0) ld_pend--;
            if (!(ld_hold && ld_pend > 0)) ld_req = 0;
        end else if (ld_req && (ld_pend <= 0 || (rnd && $urandom_range(0, 15) == 0))) begin
            ld_req = 0;
        end else if (!ld_req && ld_pend > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
            ld_req = 1;
            if (rnd) ld_addr = AW'($urandom_range(0, 15));
        end
        if (st_ack) begin
            if (st_pend > 0) st_pend--;
            if (!(st_hold && st_pend > 0)) st_req = 0;
        end else if (st_req && (st_pend <= 0 || (rnd && $urandom_range(0, 15) == 0))) begin
            st_req = 0;
        end else if (!st_req && st_pend > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
            st_req = 1;
            if (rnd) begin
                st_addr = AW'($urandom_range(0, 15));
                st_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    endtask

    task automatic master_stim();
        if (!mdone && !mpend && init_o) begin
            mpend = 1;
            mcnt = rnd ? $urandom_range(0, 4) : dly_knob;
        end
        if (err_knob && mpend && mcnt == 1) begin
            err_in = 1; err_knob = 0;
        end else begin
            err_in = rnd && ($urandom_range(0, 7) == 0);
        end
        if (mpend) begin
            if (mcnt == 0) begin
                mdone = 1; mpend = 0;
                mhold = rnd ? $urandom_range(0, 3) : hold_knob;
                if (mode_o == 2'b10) mst_mem[addra_o] = wdata_o;
            end else begin
                mcnt--;
            end
        end else if (mdone && !init_o) begin
            if (mhold == 0) mdone = 0;
            else mhold--;
        end
        done_in = mdone | force_done;
        rdata_in = mst_mem[addrb_o];
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        if (rst_rel) begin
            rst_n = 1; rst_rel = 0;
        end
        req_stim();
        master_stim();
        model_step();
    endtask

    function automatic logic ev(input int w);
        case (w)
            0: return ld_ack;
            1: return st_ack;
            2: return ld_done;
            default: return st_done;
        endcase
    endfunction

    task automatic wait_ev(input int w, input string nm, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ev(w) && n < 60);
        checks++;
        if (!ev(w)) begin
            errs++;
            $display("FAIL timeout %s: no event within %0d cycles, required one", nm, n);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || ld_req || st_req || done_in) && n < 400) begin
            tick();
            n++;
        end
        chk("drain_idle", {busy, ld_req, st_req, done_in}, 0);
    endtask

    int n;
    int ng;
    int g [0:3];

    initial begin : wd
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mst_mem[i] = '0;
            ref_mem[i] = '0;
        end
        model_reset();
        repeat (3) tick();
        rst_rel = 1;
        repeat (2) tick();
        chk("rst_mode", mode_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_init", init_o, 0);
        chk("rst_cnt", txn_cnt, 0);

        // single store
        dly_knob = 2; st_addr = 9'h005; st_wdata = 128'h19; st_pend = 1;
        wait_ev(1, "store_ack", n);
        chk("st_mode", mode_o, 2'b10);
        chk("st_addra", addra_o, 9'h005);
        chk("st_wdata", wdata_o, 128'h19);
        chk("st_init", init_o, 1);
        wait_ev(3, "store_done", n);
        chk("st_err0", st_err, 0);
        chk("st_cnt1", txn_cnt, 1);
        tick();
        chk("st_done_pulse", st_done, 0);

        // single load of the stored word
        drain();
        ld_addr = 9'h005; ld_pend = 1;
        wait_ev(0, "load_ack", n);
        chk("ld_mode", mode_o, 2'b01);
        chk("ld_addrb", addrb_o, 9'h005);
        chk("ld_addra_kept", addra_o, 9'h005);
        wait_ev(2, "load_done", n);
        chk("ld_rdata", ld_rdata, 128'h19);
        repeat (3) tick();
        chk("ld_rdata_held", ld_rdata, 128'h19);

        // error pulse mid-transaction on a store, then a clean one
        drain();
        dly_knob = 3; err_knob = 1; st_addr = 9'h007; st_wdata = 128'h33; st_pend = 1;
        wait_ev(3, "err_store_done", n);
        chk("st_err1", st_err, 1);
        drain();
        st_pend = 1;
        wait_ev(3, "clean_store_done", n);
        chk("st_err_clear", st_err, 0);

        // simultaneous held requests
        drain();
        dly_knob = 1; ld_hold = 1; st_hold = 1; ld_addr = 9'h007; st_addr = 9'h00a;
        st_wdata = 128'hab; ld_pend = 4; st_pend = 4; ng = 0; n = 0;
        while (ng < 4 && n < 300) begin
            tick();
            n++;
            if (ld_ack) begin g[ng] = 0; ng++; end
            else if (st_ack) begin g[ng] = 1; ng++; end
        end
        chk("tie_count", ng, 4);
`ifdef SA_ARB_FIXED_PRIO_EN
        chk("tie_g0", g[0], 0); chk("tie_g1", g[1], 0); chk("tie_g2", g[2], 0); chk("tie_g3", g[3], 0);
`else
        chk("tie_g0", g[0], 0); chk("tie_g1", g[1], 1); chk("tie_g2", g[2], 0); chk("tie_g3", g[3], 1);
`endif
        drain();
        ld_hold = 0; st_hold = 0;

        // txn_done held after init drops with a store waiting
        hold_knob = 3; st_addr = 9'h00b; st_pend = 2;
        wait_ev(3, "held_first_done", n);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 4) begin
                chk("held_idle_mode", mode_o, 0);
                chk("held_idle_busy", busy, 0);
            end
        end while (!st_ack && n < 30);
        chk("held_ack_gap", n, 5);
        hold_knob = 0;
        drain();

        // txn_done high while idle blocks the grant
        force_done = 1; st_addr = 9'h003; st_pend = 1;
        repeat (3) begin
            tick();
            chk("forced_no_ack", st_ack, 0);
        end
        force_done = 0;
        wait_ev(1, "forced_release_ack", n);
        chk("forced_ack_gap", n, 2);
        drain();

        // asynchronous reset mid-transaction
        dly_knob = 6; ld_addr = 9'h009; ld_pend = 1;
        wait_ev(0, "rst_ld_ack", n);
        tick();
        tick();
        rst_n = 0;
        #1;
        chk("arst_init", init_o, 0);
        chk("arst_mode", mode_o, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cnt", txn_cnt, 0);
        model_reset();
        mpend = 0; mdone = 0; err_in = 0; done_in = 0;
        ld_req = 1; ld_pend = 1;
        repeat (2) tick();
        rst_rel = 1;
        wait_ev(0, "rst_regrant", n);
        chk("rst_regrant_gap", n, 2);
        dly_knob = 1;
        wait_ev(2, "rst_redone", n);
        chk("rst_cnt_after", txn_cnt, 1);
        drain();

        // random traffic
        rnd = 1; ld_pend = 1000000; st_pend = 1000000;
        repeat (3000) tick();
        rnd = 0; ld_pend = 0; st_pend = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
